thread_lsu: RTL

- Per-thread load/store unit; the memory-side producer of the register file's MEMORY writeback source (lsu_out) and the consumer of its rs/rt read ports.
- Converts a decoded LDR/STR into a valid/ready transaction toward the memory controller.
- Reports progress to the core scheduler via lsu_state.
- One instance per thread, beside that thread's register file and ALU.

---
 rtl/thread_lsu.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/thread_lsu.sv
// thread_lsu: per-thread load/store unit.
// Turns a decoded LDR/STR into a valid/ready transaction toward the memory
// controller and reports progress to the core scheduler through lsu_state.
// Ports:
//   clk, reset (async, active low), enable (low freezes all state)
//   core_state                         - core FSM state (REQUEST/WAIT/UPDATE)
//   dec_mem_read_en / dec_mem_write_en - decoded LDR / STR
//   rs, rt                             - address / store data from register file
//   mem_read_*                         - read channel (valid/address out, ready/data in)
//   mem_write_*                        - write channel (valid/address/data out, ready in)
//   lsu_state                          - 00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE
//   lsu_out                            - last loaded value (MEMORY writeback source)
module thread_lsu #(
  parameter int addr_bits = 8,
  parameter int data_bits = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 dec_mem_read_en,
  input  logic                 dec_mem_write_en,
  input  logic [data_bits-1:0] rs,
  input  logic [data_bits-1:0] rt,
  output logic                 mem_read_valid,
  output logic [addr_bits-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [data_bits-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [addr_bits-1:0] mem_write_address,
  output logic [data_bits-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [1:0]           lsu_state,
  output logic [data_bits-1:0] lsu_out
);

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    REQUESTING = 2'b01,
    WAITING    = 2'b10,
    DONE       = 2'b11
  } lsu_state_e;

  lsu_state_e           state_q, state_d;
  logic                 is_read_q, is_read_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [addr_bits-1:0] rd_addr_q, rd_addr_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [addr_bits-1:0] wr_addr_q, wr_addr_d;
  logic [data_bits-1:0] wr_data_q, wr_data_d;
  logic [data_bits-1:0] out_q, out_d;
  logic [addr_bits-1:0] rs_addr;
  logic                 start;
  logic                 ready_in_use;

  // Address operand sized to the address bus (zero-extend when wider).
  generate
    if (addr_bits > data_bits) begin : g_zext
      assign rs_addr = {{(addr_bits-data_bits){1'b0}}, rs};
    end else begin : g_trunc
      assign rs_addr = rs[addr_bits-1:0];
    end
  endgenerate

  assign start        = (core_state == CORE_REQUEST) && (dec_mem_read_en || dec_mem_write_en);
  // Only the channel carrying the current transaction may complete it.
  assign ready_in_use = is_read_q ? mem_read_ready : mem_write_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      state_q <= IDLE;
    else if (enable) state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (start) state_d = REQUESTING;
      REQUESTING: state_d = WAITING;
      WAITING:    if (ready_in_use) state_d = DONE;
      DONE:       if (core_state == CORE_UPDATE) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    is_read_d  = is_read_q;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    out_d      = out_q;
    unique case (state_q)
      // Read wins when both enables are decoded.
      IDLE: if (start) is_read_d = dec_mem_read_en;
      // rs/rt were latched by the register file on the REQUEST edge.
      REQUESTING: begin
        if (is_read_q) begin
          rd_valid_d = 1'b1;
          rd_addr_d  = rs_addr;
        end else begin
          wr_valid_d = 1'b1;
          wr_addr_d  = rs_addr;
          wr_data_d  = rt;
        end
      end
      WAITING: begin
        if (is_read_q && mem_read_ready) begin
          out_d      = mem_read_data;
          rd_valid_d = 1'b0;
        end else if (!is_read_q && mem_write_ready) begin
          wr_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_read_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      out_q      <= '0;
    end else if (enable) begin
      is_read_q  <= is_read_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      out_q      <= out_d;
    end
  end

  assign mem_read_valid    = rd_valid_q;
  assign mem_read_address  = rd_addr_q;
  assign mem_write_valid   = wr_valid_q;
  assign mem_write_address = wr_addr_q;
  assign mem_write_data    = wr_data_q;
  assign lsu_state         = state_q;
  assign lsu_out           = out_q;

endmodule
